// File: rtl/account_manager_if.sv
// Account manager bus: groups the card/password/transaction inputs and the
// balance/status outputs of account_manager.
//   master : drives card_in, card_number, psw_valid, password_input, op_done,
//            updated_balance, cfg_we, cfg_addr, cfg_psw, cfg_bal;
//            observes balance, session_active and the four status pulses.
//   slave  : the account_manager side (directions reversed).
interface account_manager_if #(
  parameter int unsigned CARD_W = 3,
  parameter int unsigned PSW_W  = 16,
  parameter int unsigned BAL_W  = 20
);
  logic              card_in;
  logic [CARD_W-1:0] card_number;
  logic              psw_valid;
  logic [PSW_W-1:0]  password_input;
  logic              op_done;
  logic [BAL_W-1:0]  updated_balance;
  logic              cfg_we;
  logic [CARD_W-1:0] cfg_addr;
  logic [PSW_W-1:0]  cfg_psw;
  logic [BAL_W-1:0]  cfg_bal;

  logic [BAL_W-1:0]  balance;
  logic              session_active;
  logic              auth_ok;
  logic              wrong_psw;
  logic              card_locked;
  logic              invalid_card;

  modport master (
    output card_in, card_number, psw_valid, password_input, op_done, updated_balance,
           cfg_we, cfg_addr, cfg_psw, cfg_bal,
    input  balance, session_active, auth_ok, wrong_psw, card_locked, invalid_card
  );

  modport slave (
    input  card_in, card_number, psw_valid, password_input, op_done, updated_balance,
           cfg_we, cfg_addr, cfg_psw, cfg_bal,
    output balance, session_active, auth_ok, wrong_psw, card_locked, invalid_card
  );
endinterface

// File: rtl/account_manager.sv
// Account manager: small ATM-style account database with card session FSM.
// Holds per-account password, balance, wrong-try counter and lock flag.
// A card session authenticates by password, then lets the host commit new
// balances until the card is removed. Too many wrong passwords lock the account.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset (clears FSM, outputs and database)
//   io_bus : account_manager_if.slave (inputs, balance/session/status outputs)
// All outputs are registered; status pulses last one cycle and are exclusive.
module account_manager #(
  parameter int unsigned CARD_W    = 3,
  parameter int unsigned PSW_W     = 16,
  parameter int unsigned BAL_W     = 20,
  parameter int unsigned USERS     = 8,
  parameter int unsigned MAX_TRIES = 3
) (
  input logic               clk,
  input logic               rst,
  account_manager_if.slave  io_bus
);

  localparam int unsigned TryW = $clog2(MAX_TRIES + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAuth   = 2'd1;
  localparam logic [1:0] StActive = 2'd2;
  localparam logic [1:0] StEject  = 2'd3;

  // Database
  logic [PSW_W-1:0]  r_psw   [USERS];
  logic [BAL_W-1:0]  r_bal   [USERS];
  logic [TryW-1:0]   r_tries [USERS];
  logic              r_lock  [USERS];

  // Session state and registered outputs
  logic [1:0]        r_state;
  logic [CARD_W-1:0] r_idx;
  logic [BAL_W-1:0]  r_balance;
  logic              r_session;
  logic              r_auth_ok;
  logic              r_wrong_psw;
  logic              r_card_locked;
  logic              r_invalid_card;

  // Next-state values
  logic [1:0]        w_state;
  logic [CARD_W-1:0] w_idx;
  logic [BAL_W-1:0]  w_balance;
  logic              w_auth_ok;
  logic              w_wrong_psw;
  logic              w_card_locked;
  logic              w_invalid_card;

  // Database write controls
  logic              w_cfg_wr;
  logic              w_commit;
  logic              w_tries_we;
  logic [TryW-1:0]   w_tries_val;
  logic              w_lock_set;

  // Lookups
  logic              w_card_ok;
  logic              w_cfg_ok;
  logic              w_card_lock;
  logic [PSW_W-1:0]  w_sel_psw;
  logic [BAL_W-1:0]  w_sel_bal;
  logic [TryW-1:0]   w_sel_tries;
  logic [TryW-1:0]   w_tries_inc;

  assign w_card_ok = 32'(io_bus.card_number) < USERS;
  assign w_cfg_ok  = 32'(io_bus.cfg_addr) < USERS;

  // Lookups are written as mux loops so an out-of-range index never addresses
  // an array entry; range checks above gate their use.
  always_comb begin
    w_card_lock = 1'b0;
    w_sel_psw   = '0;
    w_sel_bal   = '0;
    w_sel_tries = '0;
    for (int unsigned i = 0; i < USERS; i++) begin
      if (CARD_W'(i) == io_bus.card_number) w_card_lock = r_lock[i];
      if (CARD_W'(i) == r_idx) begin
        w_sel_psw   = r_psw[i];
        w_sel_bal   = r_bal[i];
        w_sel_tries = r_tries[i];
      end
    end
  end

  // A live counter is always below MAX_TRIES, so the increment cannot wrap.
  assign w_tries_inc = w_sel_tries + TryW'(1);

  always_comb begin
    w_state        = r_state;
    w_idx          = r_idx;
    w_balance      = r_balance;
    w_auth_ok      = 1'b0;
    w_wrong_psw    = 1'b0;
    w_card_locked  = 1'b0;
    w_invalid_card = 1'b0;
    w_cfg_wr       = 1'b0;
    w_commit       = 1'b0;
    w_tries_we     = 1'b0;
    w_tries_val    = '0;
    w_lock_set     = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (io_bus.card_in) begin
          if (!w_card_ok) begin
            w_invalid_card = 1'b1;
            w_state        = StEject;
          end else if (w_card_lock) begin
            w_card_locked = 1'b1;
            w_state       = StEject;
          end else begin
            w_idx   = io_bus.card_number;
            w_state = StAuth;
          end
        end else if (io_bus.cfg_we && w_cfg_ok) begin
          w_cfg_wr = 1'b1;
        end
      end

      StAuth: begin
        // Card removal wins over a password strobe in the same cycle.
        if (!io_bus.card_in) begin
          w_state = StIdle;
        end else if (io_bus.psw_valid) begin
          w_tries_we = 1'b1;
          if (io_bus.password_input == w_sel_psw) begin
            w_auth_ok   = 1'b1;
            w_balance   = w_sel_bal;
            w_tries_val = '0;
            w_state     = StActive;
          end else begin
            w_tries_val = w_tries_inc;
            if (w_tries_inc == TryW'(MAX_TRIES)) begin
              // Final strike reports only the lockout to keep pulses exclusive.
              w_lock_set    = 1'b1;
              w_card_locked = 1'b1;
              w_state       = StEject;
            end else begin
              w_wrong_psw = 1'b1;
            end
          end
        end
      end

      StActive: begin
        if (io_bus.op_done) begin
          w_commit  = 1'b1;
          w_balance = io_bus.updated_balance;
        end
        if (!io_bus.card_in) begin
          w_balance = '0;
          w_state   = StIdle;
        end
      end

      StEject: begin
        if (!io_bus.card_in) w_state = StIdle;
      end

      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= StIdle;
      r_idx          <= '0;
      r_balance      <= '0;
      r_session      <= 1'b0;
      r_auth_ok      <= 1'b0;
      r_wrong_psw    <= 1'b0;
      r_card_locked  <= 1'b0;
      r_invalid_card <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_idx          <= w_idx;
      r_balance      <= w_balance;
      r_session      <= (w_state == StActive);
      r_auth_ok      <= w_auth_ok;
      r_wrong_psw    <= w_wrong_psw;
      r_card_locked  <= w_card_locked;
      r_invalid_card <= w_invalid_card;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < USERS; i++) begin
        r_psw[i]   <= '0;
        r_bal[i]   <= '0;
        r_tries[i] <= '0;
        r_lock[i]  <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < USERS; i++) begin
        if (w_cfg_wr && (CARD_W'(i) == io_bus.cfg_addr)) begin
          r_psw[i]   <= io_bus.cfg_psw;
          r_bal[i]   <= io_bus.cfg_bal;
          r_tries[i] <= '0;
          r_lock[i]  <= 1'b0;
        end else if (CARD_W'(i) == r_idx) begin
          if (w_commit)   r_bal[i]   <= io_bus.updated_balance;
          if (w_tries_we) r_tries[i] <= w_tries_val;
          if (w_lock_set) r_lock[i]  <= 1'b1;
        end
      end
    end
  end

  assign io_bus.balance        = r_balance;
  assign io_bus.session_active = r_session;
  assign io_bus.auth_ok        = r_auth_ok;
  assign io_bus.wrong_psw      = r_wrong_psw;
  assign io_bus.card_locked    = r_card_locked;
  assign io_bus.invalid_card   = r_invalid_card;

endmodule

// File: tb/tb_account_manager.sv
// Directed self-checking bench for account_manager.
// CARD_W is widened to 4 so card number 8 (out of range for USERS=8) can be driven.
module tb_account_manager;

  localparam int unsigned CARD_W    = 4;
  localparam int unsigned PSW_W     = 16;
  localparam int unsigned BAL_W     = 20;
  localparam int unsigned USERS     = 8;
  localparam int unsigned MAX_TRIES = 3;

  // Status pulse encoding used in checks: {auth_ok, wrong_psw, card_locked, invalid_card}
  localparam logic [3:0] PNone    = 4'b0000;
  localparam logic [3:0] PAuth    = 4'b1000;
  localparam logic [3:0] PWrong   = 4'b0100;
  localparam logic [3:0] PLocked  = 4'b0010;
  localparam logic [3:0] PInvalid = 4'b0001;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  account_manager_if #(.CARD_W(CARD_W), .PSW_W(PSW_W), .BAL_W(BAL_W)) bus ();

  account_manager #(
    .CARD_W   (CARD_W),
    .PSW_W    (PSW_W),
    .BAL_W    (BAL_W),
    .USERS    (USERS),
    .MAX_TRIES(MAX_TRIES)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] pulses();
    return {bus.auth_ok, bus.wrong_psw, bus.card_locked, bus.invalid_card};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [CARD_W-1:0] addr, input logic [PSW_W-1:0] psw,
                           input logic [BAL_W-1:0] bal);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_psw  = psw;
    bus.cfg_bal  = bal;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic enter_psw(input logic [PSW_W-1:0] psw);
    bus.password_input = psw;
    bus.psw_valid      = 1'b1;
    step();
    bus.psw_valid = 1'b0;
  endtask

  task automatic card_insert(input logic [CARD_W-1:0] num);
    bus.card_number = num;
    bus.card_in     = 1'b1;
    step();
  endtask

  task automatic card_remove();
    bus.card_in = 1'b0;
    step();
  endtask

  initial begin
    n_checks            = 0;
    n_fail              = 0;
    bus.card_in         = 1'b0;
    bus.card_number     = '0;
    bus.psw_valid       = 1'b0;
    bus.password_input  = '0;
    bus.op_done         = 1'b0;
    bus.updated_balance = '0;
    bus.cfg_we          = 1'b0;
    bus.cfg_addr        = '0;
    bus.cfg_psw         = '0;
    bus.cfg_bal         = '0;
    rst                 = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_eq("reset_balance", 32'(bus.balance), 32'd0);
    check_eq("reset_session", 32'(bus.session_active), 32'd0);
    check_eq("reset_pulses", 32'(pulses()), 32'(PNone));
    @(negedge clk);
    rst = 1'b1;
    step();

    // Configure account 2 and authenticate
    cfg_write(4'd2, 16'h1234, 20'd500);
    card_insert(4'd2);
    check_eq("auth_wait_pulses", 32'(pulses()), 32'(PNone));
    check_eq("auth_wait_session", 32'(bus.session_active), 32'd0);
    enter_psw(16'h1234);
    check_eq("auth_ok_pulse", 32'(pulses()), 32'(PAuth));
    check_eq("auth_balance", 32'(bus.balance), 32'd500);
    check_eq("auth_session", 32'(bus.session_active), 32'd1);
    step();
    check_eq("auth_pulse_single", 32'(pulses()), 32'(PNone));

    // Config write while active must be ignored; card_number change ignored
    cfg_write(4'd2, 16'hFFFF, 20'd7);
    check_eq("cfg_active_bal", 32'(bus.balance), 32'd500);
    bus.card_number     = 4'd5;
    bus.op_done         = 1'b1;
    bus.updated_balance = 20'd320;
    step();
    bus.op_done = 1'b0;
    check_eq("commit_balance", 32'(bus.balance), 32'd320);
    check_eq("commit_session", 32'(bus.session_active), 32'd1);
    card_remove();
    check_eq("remove_balance", 32'(bus.balance), 32'd0);
    check_eq("remove_session", 32'(bus.session_active), 32'd0);
    card_insert(4'd2);
    enter_psw(16'h1234);
    check_eq("reauth_pulse", 32'(pulses()), 32'(PAuth));
    check_eq("reauth_balance", 32'(bus.balance), 32'd320);
    card_remove();

    // Three wrong passwords lock account 2
    card_insert(4'd2);
    enter_psw(16'h0000);
    check_eq("wrong1", 32'(pulses()), 32'(PWrong));
    step();
    enter_psw(16'h0000);
    check_eq("wrong2", 32'(pulses()), 32'(PWrong));
    enter_psw(16'h0000);
    check_eq("wrong3_locked", 32'(pulses()), 32'(PLocked));
    check_eq("wrong3_session", 32'(bus.session_active), 32'd0);
    enter_psw(16'h1234);
    check_eq("eject_ignores_psw", 32'(pulses()), 32'(PNone));
    check_eq("eject_session", 32'(bus.session_active), 32'd0);
    card_remove();
    card_insert(4'd2);
    check_eq("locked_reinsert", 32'(pulses()), 32'(PLocked));
    step();
    check_eq("locked_eject_hold", 32'(pulses()), 32'(PNone));
    card_remove();
    cfg_write(4'd2, 16'h1234, 20'd77);
    card_insert(4'd2);
    check_eq("unlock_no_pulse", 32'(pulses()), 32'(PNone));
    enter_psw(16'h1234);
    check_eq("unlock_auth", 32'(pulses()), 32'(PAuth));
    check_eq("unlock_balance", 32'(bus.balance), 32'd77);
    card_remove();

    // Try counter survives card removal; removal beats a password strobe
    cfg_write(4'd3, 16'hBEEF, 20'd1000);
    card_insert(4'd3);
    enter_psw(16'h0001);
    check_eq("a3_wrong1", 32'(pulses()), 32'(PWrong));
    enter_psw(16'h0002);
    check_eq("a3_wrong2", 32'(pulses()), 32'(PWrong));
    bus.card_in        = 1'b0;
    bus.password_input = 16'hBEEF;
    bus.psw_valid      = 1'b1;
    step();
    bus.psw_valid = 1'b0;
    check_eq("remove_beats_psw", 32'(pulses()), 32'(PNone));
    check_eq("remove_beats_psw_sess", 32'(bus.session_active), 32'd0);
    card_insert(4'd3);
    enter_psw(16'h0003);
    check_eq("a3_retained_lock", 32'(pulses()), 32'(PLocked));
    card_remove();

    // Out-of-range card
    card_insert(4'd8);
    check_eq("invalid_pulse", 32'(pulses()), 32'(PInvalid));
    check_eq("invalid_balance", 32'(bus.balance), 32'd0);
    step();
    check_eq("invalid_hold", 32'(pulses()), 32'(PNone));
    card_remove();
    card_insert(4'd2);
    check_eq("after_invalid_idle", 32'(pulses()), 32'(PNone));
    enter_psw(16'h1234);
    check_eq("a2_auth_77", 32'(bus.balance), 32'd77);

    // Commit with simultaneous card removal
    bus.op_done         = 1'b1;
    bus.updated_balance = 20'd99;
    bus.card_in         = 1'b0;
    step();
    bus.op_done = 1'b0;
    check_eq("commit_remove_balance", 32'(bus.balance), 32'd0);
    check_eq("commit_remove_session", 32'(bus.session_active), 32'd0);
    card_insert(4'd2);
    enter_psw(16'h1234);
    check_eq("commit_remove_kept", 32'(bus.balance), 32'd99);

    // Reset mid-session with a commit pending
    bus.op_done         = 1'b1;
    bus.updated_balance = 20'd555;
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_balance", 32'(bus.balance), 32'd0);
    check_eq("midrst_session", 32'(bus.session_active), 32'd0);
    check_eq("midrst_pulses", 32'(pulses()), 32'(PNone));
    bus.op_done = 1'b0;
    bus.card_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    card_insert(4'd2);
    enter_psw(16'h0000);
    check_eq("postrst_auth_zero_psw", 32'(pulses()), 32'(PAuth));
    check_eq("postrst_balance", 32'(bus.balance), 32'd0);
    card_remove();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
